// File: rtl/servo_pkg.sv
// Shared definitions for servo_angle_ctrl: FSM state encoding and the
// helpers that turn clock/microsecond parameters into tick counts.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    LOAD
  } state_e;

  function automatic logic [31:0] ticks_from_us(input int unsigned clk_freq,
                                                input int unsigned us);
    return 32'((clk_freq / 1_000_000) * us);
  endfunction

  function automatic logic [31:0] period_ticks(input int unsigned clk_freq,
                                               input int unsigned pwm_freq);
    return 32'(clk_freq / pwm_freq);
  endfunction

endpackage

// File: rtl/udiv_serial.sv
// 32-bit restoring divider: one quotient bit per cycle, 32 iterations after
// the start cycle, done is a single-cycle pulse with the quotient valid.
module udiv_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic        done
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] div_q, div_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [32:0] shifted;

  always_comb begin
    quo_d   = quo_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[31]};
    if (start) begin
      quo_d  = dividend;
      div_d  = divisor;
      rem_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // remainder stays below divisor, so it always fits back into 32 bits
      if (shifted >= {1'b0, div_q}) begin
        rem_d = 32'(shifted - {1'b0, div_q});
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      div_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      div_q  <= div_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/servo_angle_ctrl.sv
// Angle command to PWM duty converter with frame-aligned duty updates.
// Define SERVO_SLEW_EN to limit the duty change per frame to STEP_US.
module servo_angle_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter int unsigned PWM_FREQ     = 50,
  parameter int unsigned MIN_PULSE_US = 1000,
  parameter int unsigned MAX_PULSE_US = 2000,
  parameter int unsigned MAX_ANGLE    = 180,
  parameter int unsigned STEP_US      = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_angle,
  output logic        cmd_ready,
  output logic [31:0] duty_cycle,
  output logic [31:0] period,
  output logic        frame_tick,
  output logic        at_target
);

  localparam logic [31:0] PERIOD = period_ticks(CLK_FREQ, PWM_FREQ);
  localparam logic [31:0] MIN_T  = ticks_from_us(CLK_FREQ, MIN_PULSE_US);
  localparam logic [31:0] MAX_T  = ticks_from_us(CLK_FREQ, MAX_PULSE_US);
  localparam logic [31:0] SPAN   = MAX_T - MIN_T;
  localparam logic [31:0] STEP_T = ticks_from_us(CLK_FREQ, STEP_US);
  localparam logic [31:0] CENTER = MIN_T + (SPAN >> 1);
`ifdef SERVO_SLEW_EN
  localparam logic [31:0] SLEW_LIM = STEP_T;
`else
  // duty and target both lie in [MIN_T, MAX_T], so a limit of at least SPAN never binds
  localparam logic [31:0] SLEW_LIM = (STEP_T > SPAN) ? STEP_T : SPAN;
`endif

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] duty_q, duty_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic        at_target_q, at_target_d;

  logic        div_start;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] angle_sat;
  logic [31:0] dividend;
  logic [31:0] diff;
  logic [31:0] step;

  assign angle_sat = ({24'd0, cmd_angle} > MAX_ANGLE) ? MAX_ANGLE : {24'd0, cmd_angle};
  assign dividend  = angle_sat * SPAN;

  udiv_serial u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (MAX_ANGLE),
    .quotient (div_quo),
    .done     (div_done)
  );

  assign frame_tick = (frame_cnt_q == PERIOD - 32'd1);

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    duty_d      = duty_q;
    div_start   = 1'b0;
    frame_cnt_d = frame_tick ? '0 : frame_cnt_q + 32'd1;
    diff        = (target_q > duty_q) ? target_q - duty_q : duty_q - target_q;
    step        = (diff > SLEW_LIM) ? SLEW_LIM : diff;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          div_start = 1'b1;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (div_done) state_d = LOAD;
      end
      LOAD: begin
        target_d = MIN_T + div_quo;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // frame update reads target_q, so a same-edge target write lands next frame
    if (frame_tick) begin
      duty_d = (target_q > duty_q) ? duty_q + step : duty_q - step;
    end

    at_target_d = (duty_d == target_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      target_q    <= CENTER;
      duty_q      <= CENTER;
      frame_cnt_q <= '0;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      duty_q      <= duty_d;
      frame_cnt_q <= frame_cnt_d;
      at_target_q <= at_target_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign duty_cycle = duty_q;
  assign period     = PERIOD;
  assign at_target  = at_target_q;

endmodule
